// File: rtl/tlb_ctrl.sv
// rtl/tlb_ctrl.sv - TLB maintenance op sequencer (TLBWI/TLBWR/TLBP/TLBR) with CP0 Random counter
module tlb_ctrl #(
    parameter int N_ENTRIES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_valid,
    input  logic [1:0]                    op_code,
    output logic                          op_ready,
    output logic                          op_done,
    input  logic [31:0]                   entryhi,
    input  logic [31:0]                   entrylo0,
    input  logic [31:0]                   entrylo1,
    input  logic [$clog2(N_ENTRIES)-1:0]  index_in,
    input  logic [$clog2(N_ENTRIES)-1:0]  wired_in,
    input  logic                          wired_we,
    output logic [$clog2(N_ENTRIES)-1:0]  random_out,
    output logic [79+$clog2(N_ENTRIES):0] tlb_config,
    output logic                          tlbwi,
    output logic                          tlbp,
    input  logic [31:0]                   tlbp_result,
    output logic [$clog2(N_ENTRIES)-1:0]  tlbr_index,
    input  logic [79:0]                   tlbr_entry,
    output logic                          index_we,
    output logic [31:0]                   index_out,
    output logic                          entry_we,
    output logic [31:0]                   entryhi_out,
    output logic [31:0]                   entrylo0_out,
    output logic [31:0]                   entrylo1_out
);
    localparam int IW = $clog2(N_ENTRIES);
    localparam logic [IW-1:0] RAND_TOP = IW'(N_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_PROBE,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    r_random;
    logic [79+IW:0]   r_cfg;
    logic [31:0]      r_index_out;
    logic [31:0]      r_entryhi_out;
    logic [31:0]      r_entrylo0_out;
    logic [31:0]      r_entrylo1_out;
    logic             w_accept;
    logic [IW-1:0]    w_idx;
    logic [79+IW:0]   w_cfg;
    logic             w_unused;

    assign w_accept = (r_state == S_IDLE) && op_valid;
    assign w_idx    = (op_code == 2'b01) ? r_random : index_in;
    assign w_cfg    = {entryhi[7:0], entrylo0[0] & entrylo1[0], entryhi[31:13],
                       entrylo1[29:6], entrylo1[2], entrylo1[1],
                       entrylo0[29:6], entrylo0[2], entrylo0[1], w_idx};
    assign w_unused = &{1'b0, entryhi[12:8], entrylo0[31:30], entrylo0[5:3],
                        entrylo1[31:30], entrylo1[5:3], tlbp_result[30:IW]};

    // Random wraps to the top whenever it reaches Wired, so it never selects a wired entry
    always_ff @(posedge clk) begin
        if (rst || wired_we || (r_random == wired_in)) begin
            r_random <= RAND_TOP;
        end else begin
            r_random <= r_random - 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        2'b10:   w_next = S_PROBE;
                        2'b11:   w_next = S_RD_REQ;
                        default: w_next = S_WRITE;
                    endcase
                end
            end
            S_WRITE:   w_next = S_DONE;
            S_PROBE:   w_next = S_DONE;
            S_RD_REQ:  w_next = S_RD_WAIT;
            S_RD_WAIT: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_op           <= 2'b00;
            r_idx          <= '0;
            r_cfg          <= '0;
            r_index_out    <= '0;
            r_entryhi_out  <= '0;
            r_entrylo0_out <= '0;
            r_entrylo1_out <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= op_code;
                r_idx <= w_idx;
                // TLBR never drives the array's write/probe path, so the config word is left alone
                if (op_code != 2'b11) begin
                    r_cfg <= w_cfg;
                end
            end
            if (r_state == S_PROBE) begin
                r_index_out <= tlbp_result[31] ? {1'b1, 31'b0}
                                               : {1'b0, {(31-IW){1'b0}}, tlbp_result[IW-1:0]};
            end
            if (r_state == S_RD_WAIT) begin
                r_entryhi_out  <= {tlbr_entry[70:52], 5'b0, tlbr_entry[79:72]};
                r_entrylo0_out <= {2'b0, tlbr_entry[25:2], 3'b0, tlbr_entry[1], tlbr_entry[0], tlbr_entry[71]};
                r_entrylo1_out <= {2'b0, tlbr_entry[51:28], 3'b0, tlbr_entry[27], tlbr_entry[26], tlbr_entry[71]};
            end
        end
    end

    // Strobes are masked by rst so an interrupted op cannot leak a pulse in the reset cycle
    assign op_ready     = (r_state == S_IDLE) && !rst;
    assign tlbwi        = (r_state == S_WRITE) && !rst;
    assign tlbp         = (r_state == S_PROBE) && !rst;
    assign op_done      = (r_state == S_DONE) && !rst;
    assign index_we     = (r_state == S_DONE) && (r_op == 2'b10) && !rst;
    assign entry_we     = (r_state == S_DONE) && (r_op == 2'b11) && !rst;
    assign random_out   = r_random;
    assign tlb_config   = r_cfg;
    assign tlbr_index   = r_idx;
    assign index_out    = r_index_out;
    assign entryhi_out  = r_entryhi_out;
    assign entrylo0_out = r_entrylo0_out;
    assign entrylo1_out = r_entrylo1_out;
endmodule

// File: tb/tb_tlb_ctrl.sv
// tb/tb_tlb_ctrl.sv - randomized scoreboard bench for tlb_ctrl with TLB array and Random models
module tb_tlb_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready, op_done;
    logic [31:0] entryhi, entrylo0, entrylo1;
    logic [3:0]  index_in, wired_in;
    logic        wired_we;
    logic [3:0]  random_out;
    logic [83:0] tlb_config;
    logic        tlbwi, tlbp;
    logic [31:0] tlbp_result;
    logic [3:0]  tlbr_index;
    logic [79:0] tlbr_entry;
    logic        index_we, entry_we;
    logic [31:0] index_out, entryhi_out, entrylo0_out, entrylo1_out;

    tlb_ctrl #(.N_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .op_done(op_done), .entryhi(entryhi),
        .entrylo0(entrylo0), .entrylo1(entrylo1), .index_in(index_in),
        .wired_in(wired_in), .wired_we(wired_we), .random_out(random_out),
        .tlb_config(tlb_config), .tlbwi(tlbwi), .tlbp(tlbp),
        .tlbp_result(tlbp_result), .tlbr_index(tlbr_index), .tlbr_entry(tlbr_entry),
        .index_we(index_we), .index_out(index_out), .entry_we(entry_we),
        .entryhi_out(entryhi_out), .entrylo0_out(entrylo0_out), .entrylo1_out(entrylo1_out)
    );

    always #5 clk = ~clk;

    localparam int K_WI = 0, K_P = 1, K_DONE = 2, K_IDX = 3, K_ENT = 4, K_RIDX = 5;
    typedef struct {
        int          kind;
        int          at;
        logic [83:0] cfg;
        logic [31:0] a, b, c;
    } ev_t;
    ev_t q[$];
    ev_t e;

    int n_checks = 0, n_pass = 0;
    int cyc = 0;
    int ready_at = 0;
    int acc_cyc = -1;
    logic [3:0]  m_rand = 4'd15;
    logic [79:0] mem [16];
    logic        mem_v [16];
    logic [79:0] ref_tlb [16];
    logic        ref_v [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference Random: reload on reset, Wired write or reaching Wired, else count down
    always @(posedge clk) begin
        if (rst || wired_we || m_rand == wired_in) m_rand <= 4'd15;
        else m_rand <= m_rand - 4'd1;
    end

    // TLB array model: write on tlbwi, registered read, combinational probe
    always @(posedge clk) begin
        if (tlbwi) begin
            mem[tlb_config[3:0]]   <= tlb_config[83:4];
            mem_v[tlb_config[3:0]] <= 1'b1;
        end
        tlbr_entry <= mem[tlbr_index];
    end

    always_comb begin
        tlbp_result = 32'h8000000F;
        for (int i = 15; i >= 0; i--)
            if (mem_v[i] && mem[i][70:52] == tlb_config[74:56] &&
                (mem[i][71] || mem[i][79:72] == tlb_config[83:76]))
                tlbp_result = {28'b0, 4'(i)};
    end

    function automatic logic [83:0] mk_cfg(input logic [31:0] eh, lo0, lo1, input logic [3:0] ix);
        return {eh[7:0], lo0[0] & lo1[0], eh[31:13], lo1[29:6], lo1[2], lo1[1],
                lo0[29:6], lo0[2], lo0[1], ix};
    endfunction

    function automatic logic [31:0] ref_probe(input logic [31:0] eh);
        for (int i = 0; i < 16; i++)
            if (ref_v[i] && ref_tlb[i][70:52] == eh[31:13] &&
                (ref_tlb[i][71] || ref_tlb[i][79:72] == eh[7:0]))
                return 32'(i);
        return 32'h80000000;
    endfunction

    task automatic issue(input logic [1:0] code, input logic [31:0] eh, lo0, lo1,
                         input logic [3:0] ix, input bit keep);
        int g = 0;
        logic [3:0]  idx;
        logic [83:0] cfg;
        logic [79:0] en;
        int t;
        while (cyc < ready_at) begin
            @(negedge clk);
            g++;
            if (g > 50) begin fail_now("ready_timeout"); return; end
        end
        op_valid = 1'b1; op_code = code; entryhi = eh; entrylo0 = lo0; entrylo1 = lo1; index_in = ix;
        idx = (code == 2'b01) ? m_rand : ix;
        cfg = mk_cfg(eh, lo0, lo1, idx);
        t = cyc; acc_cyc = t;
        case (code)
            2'b00, 2'b01: begin
                ref_tlb[idx] = cfg[83:4]; ref_v[idx] = 1'b1;
                q.push_back('{K_WI, t + 1, cfg, 0, 0, 0});
                q.push_back('{K_DONE, t + 2, 0, 0, 0, 0});
                ready_at = t + 3;
            end
            2'b10: begin
                q.push_back('{K_P, t + 1, cfg, 0, 0, 0});
                q.push_back('{K_IDX, t + 2, 0, ref_probe(eh), 0, 0});
                ready_at = t + 3;
            end
            default: begin
                en = ref_tlb[idx];
                q.push_back('{K_RIDX, t + 1, 0, 32'(idx), 0, 0});
                q.push_back('{K_ENT, t + 3, 0, {en[70:52], 5'b0, en[79:72]},
                              {2'b0, en[25:2], 3'b0, en[1], en[0], en[71]},
                              {2'b0, en[51:28], 3'b0, en[27], en[26], en[71]}});
                ready_at = t + 4;
            end
        endcase
        @(negedge clk);
        entryhi = $urandom; entrylo0 = $urandom; entrylo1 = $urandom; index_in = 4'($urandom);
        op_valid = keep;
    endtask

    // Monitor: per-cycle Random/ready checks and scoreboard pop on every strobe
    always @(negedge clk) begin
        #2;
        if (cyc >= 1) begin
            logic [4:0] s;
            chk("random_out", random_out, m_rand);
            chk("op_ready", op_ready, !rst && (cyc >= ready_at || cyc == acc_cyc));
            s = {tlbwi, tlbp, index_we, entry_we, op_done};
            if (q.size() > 0 && q[0].kind == K_RIDX && q[0].at == cyc) begin
                e = q.pop_front();
                chk("tlbr_index", tlbr_index, e.a);
            end
            if (s != 5'b0) begin
                if (q.size() == 0) fail_now($sformatf("unexpected_strobe %b", s));
                else begin
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.at);
                    case (e.kind)
                        K_WI:    begin chk("wi_strobes", s, 5'b10000); chk("wi_config", tlb_config, e.cfg); end
                        K_P:     begin chk("p_strobes", s, 5'b01000); chk("p_config", tlb_config, e.cfg); end
                        K_DONE:  chk("done_strobes", s, 5'b00001);
                        K_IDX:   begin chk("idx_strobes", s, 5'b00101); chk("index_out", index_out, e.a); end
                        default: begin
                            chk("ent_strobes", s, 5'b00011);
                            chk("entryhi_out", entryhi_out, e.a);
                            chk("entrylo0_out", entrylo0_out, e.b);
                            chk("entrylo1_out", entrylo1_out, e.c);
                        end
                    endcase
                end
            end else if (q.size() > 0 && q[0].at < cyc) begin
                e = q.pop_front();
                fail_now($sformatf("missing_event kind %0d due %0d", e.kind, e.at));
            end
        end
    end

    initial begin
        int g;
        bit keep;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0; mem_v[i] = 1'b0; ref_tlb[i] = '0; ref_v[i] = 1'b0;
        end
        rst = 1'b1; op_valid = 1'b0; op_code = 2'b00; entryhi = '0; entrylo0 = '0;
        entrylo1 = '0; index_in = '0; wired_in = 4'd3; wired_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tlb_config", tlb_config, 84'h0);
        chk("rst_index_out", index_out, 32'h0);
        chk("rst_entryhi_out", entryhi_out, 32'h0);
        chk("rst_strobes", {tlbwi, tlbp, index_we, entry_we, op_done}, 5'b0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'h0000A0FF, 32'h00000147, 32'h00000183, 4'd5, 1'b0);
        issue(2'b10, 32'h0000A0FF, 32'h0, 32'h0, 4'd0, 1'b0);
        issue(2'b10, 32'h12346011, 32'h0, 32'h0, 4'd0, 1'b0);
        issue(2'b11, 32'h0, 32'h0, 32'h0, 4'd5, 1'b0);
        issue(2'b10, 32'h0000A0FF, 32'h1, 32'h1, 4'd0, 1'b1);
        issue(2'b00, 32'h00042033, 32'h00000FC5, 32'h00000302, 4'd9, 1'b0);

        g = 0;
        while (m_rand != 4'd9 && g < 40) begin @(negedge clk); g++; end
        if (m_rand != 4'd9) fail_now("wait_random_9");
        wired_we = 1'b1; @(negedge clk); wired_we = 1'b0;
        g = 0;
        while (cyc < ready_at) @(negedge clk);
        while (m_rand != 4'd7 && g < 40) begin @(negedge clk); g++; end
        if (m_rand != 4'd7) fail_now("wait_random_7");
        issue(2'b01, 32'h0008E0AA, 32'h00000286, 32'h000002C7, 4'd0, 1'b0);
        issue(2'b11, 32'h0, 32'h0, 32'h0, 4'd7, 1'b0);

        issue(2'b11, 32'h0, 32'h0, 32'h0, 4'd5, 1'b0);
        @(negedge clk);
        rst = 1'b1; q.delete(); ready_at = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        wired_in = 4'd15;
        repeat (5) @(negedge clk);
        wired_in = 4'd2;

        for (int n = 0; n < 60; n++) begin
            keep = (n == 59) ? 1'b0 : 1'($urandom_range(0, 1));
            issue(2'($urandom_range(0, 3)),
                  {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3))},
                  $urandom, $urandom, 4'($urandom_range(0, 15)), keep);
            if (!keep && $urandom_range(0, 4) == 0) begin
                wired_in = 4'($urandom_range(0, 15));
                wired_we = 1'b1; @(negedge clk); wired_we = 1'b0;
            end
        end
        op_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
